// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared CDB sizing constants and broadcast record type
package tomasula_types;

    localparam int CDB_NUM_REQ = 4;
    localparam int ROB_TAG_W   = 3;
    localparam int CDB_DATA_W  = 32;

    typedef struct packed {
        logic [ROB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] value;
        logic                  valid;
    } cdb_data_t;

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// rtl/cdb_arbiter_rr_arbiter.sv - combinational rotating-priority one-hot arbiter
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);

    logic          found;
    logic [PW-1:0] idx;

    // Scan from ptr upward with wrap; the first requester seen wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - per-unit result holding buffers feeding a registered common data bus
module cdb_arbiter
    import tomasula_types::*;
#(
    parameter int NUM_REQ = CDB_NUM_REQ,
    parameter int TAG_W   = ROB_TAG_W,
    parameter int DATA_W  = CDB_DATA_W
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        fu_busy,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data
);

    localparam int PW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] hold_valid;
    logic [TAG_W-1:0]   hold_tag  [NUM_REQ];
    logic [DATA_W-1:0]  hold_data [NUM_REQ];
    logic [PW-1:0]      rr_ptr;
    logic [NUM_REQ-1:0] arb_grant;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] accept;
    logic [PW-1:0]      grant_idx;
    logic               grant_any;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req       (hold_valid),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (grant_idx)
    );

    // Flush suppresses the grant so nothing escapes onto the bus while squashing.
    assign grant     = flush ? '0 : arb_grant;
    assign grant_any = |grant;
    // A buffer being drained this cycle can be refilled in the same cycle.
    assign req_ready = flush ? '0 : (~hold_valid | grant);
    assign accept    = req_valid & req_ready;
    assign fu_busy   = hold_valid;

    // Holding buffers: drain on grant, fill on accept, clear on flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_valid <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                hold_tag[i]  <= '0;
                hold_data[i] <= '0;
            end
        end else if (flush) begin
            hold_valid <= '0;
        end else begin
            hold_valid <= (hold_valid & ~grant) | accept;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept[i]) begin
                    hold_tag[i]  <= req_tag[i*TAG_W +: TAG_W];
                    hold_data[i] <= req_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Registered broadcast slot and rotating pointer; tag/data hold when idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            rr_ptr    <= '0;
        end else if (grant_any) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= hold_tag[grant_idx];
            cdb_data  <= hold_data[grant_idx];
            rr_ptr    <= (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);
        end else begin
            cdb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - vector table plus reference-model scoreboard for cdb_arbiter
module tb_cdb_arbiter;
    import tomasula_types::*;

    logic         clk;
    logic         reset_n;
    logic         flush;
    logic [3:0]   req_valid;
    logic [11:0]  req_tag;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic [3:0]   fu_busy;
    logic         cdb_valid;
    logic [2:0]   cdb_tag;
    logic [31:0]  cdb_data;

    cdb_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fu_busy   (fu_busy),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        fl;
        logic [3:0]  v;
        logic [11:0] tg;
        logic [31:0] d;
        logic        cv;
        logic [2:0]  tag;
        logic [3:0]  busy;
    } vec_t;

    int          tests;
    int          fails;
    vec_t        vq[$];
    cdb_data_t   sb[$];
    logic [3:0]  m_hv;
    logic [2:0]  m_tag [4];
    logic [31:0] m_data [4];
    int          m_ptr;

    function automatic vec_t mk(input logic fl, input logic [3:0] v, input logic [11:0] tg,
                                input logic [31:0] d, input logic cv, input logic [2:0] tag,
                                input logic [3:0] busy);
        vec_t r;
        r.fl = fl; r.v = v; r.tg = tg; r.d = d; r.cv = cv; r.tag = tag; r.busy = busy;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a falling edge: drive, predict, clock, then compare at the next falling edge.
    task automatic cycle(input logic fl, input logic [3:0] v, input logic [11:0] tg, input logic [31:0] d);
        int         g;
        logic [3:0] exp_ready;
        cdb_data_t  e;
        flush     = fl;
        req_valid = v;
        req_tag   = tg;
        for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = d + 32'(i) - 32'd1;
        #1;
        g = -1;
        if (!fl)
            for (int k = 0; k < 4; k++)
                if (g < 0 && m_hv[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
        for (int i = 0; i < 4; i++) exp_ready[i] = !fl && (!m_hv[i] || g == i);
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        if (g >= 0) begin
            sb.push_back('{tag: m_tag[g], value: m_data[g], valid: 1'b1});
            m_hv[g] = 1'b0;
            m_ptr   = (g + 1) % 4;
        end
        if (fl) m_hv = '0;
        for (int i = 0; i < 4; i++)
            if (v[i] && exp_ready[i]) begin
                m_hv[i]   = 1'b1;
                m_tag[i]  = tg[i*3 +: 3];
                m_data[i] = d + 32'(i) - 32'd1;
            end
        @(posedge clk);
        @(negedge clk);
        chk("fu_busy_model", 32'(fu_busy), 32'(m_hv));
        chk("cdb_valid_vs_sb", 32'(cdb_valid), 32'(sb.size() != 0));
        if (cdb_valid && sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_tag", 32'(cdb_tag), 32'(e.tag));
            chk("sb_data", cdb_data, e.value);
        end
        sb.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0; fails = 0;
        m_hv = '0; m_ptr = 0;
        for (int i = 0; i < 4; i++) begin m_tag[i] = '0; m_data[i] = '0; end
        reset_n = 1'b0; flush = 1'b0; req_valid = '0; req_tag = '0; req_data = '0;

        // single, rotation from ptr=2, realign ptr, contention, refill, flush
        vq.push_back(mk(0, 4'b0010, {3'd0, 3'd0, 3'd5, 3'd0}, 32'hDEADBEEF, 0, 3'd0, 4'b0010));
        vq.push_back(mk(0, 4'b0000, 12'h0, 32'h0, 1, 3'd5, 4'b0000));
        vq.push_back(mk(0, 4'b0000, 12'h0, 32'h0, 0, 3'd5, 4'b0000));
        vq.push_back(mk(0, 4'b1001, {3'd7, 3'd0, 3'd0, 3'd6}, 32'h11110000, 0, 3'd5, 4'b1001));
        vq.push_back(mk(0, 4'b0000, 12'h0, 32'h0, 1, 3'd7, 4'b0001));
        vq.push_back(mk(0, 4'b0000, 12'h0, 32'h0, 1, 3'd6, 4'b0000));
        vq.push_back(mk(0, 4'b0000, 12'h0, 32'h0, 0, 3'd6, 4'b0000));
        vq.push_back(mk(0, 4'b1000, {3'd2, 3'd0, 3'd0, 3'd0}, 32'h22220000, 0, 3'd6, 4'b1000));
        vq.push_back(mk(0, 4'b0000, 12'h0, 32'h0, 1, 3'd2, 4'b0000));
        vq.push_back(mk(0, 4'b1111, {3'd4, 3'd3, 3'd2, 3'd1}, 32'h33330000, 0, 3'd2, 4'b1111));
        vq.push_back(mk(0, 4'b0000, 12'h0, 32'h0, 1, 3'd1, 4'b1110));
        vq.push_back(mk(0, 4'b0000, 12'h0, 32'h0, 1, 3'd2, 4'b1100));
        vq.push_back(mk(0, 4'b0000, 12'h0, 32'h0, 1, 3'd3, 4'b1000));
        vq.push_back(mk(0, 4'b0000, 12'h0, 32'h0, 1, 3'd4, 4'b0000));
        vq.push_back(mk(0, 4'b0000, 12'h0, 32'h0, 0, 3'd4, 4'b0000));
        vq.push_back(mk(0, 4'b0010, {3'd0, 3'd0, 3'd1, 3'd0}, 32'h44440000, 0, 3'd4, 4'b0010));
        vq.push_back(mk(0, 4'b0010, {3'd0, 3'd0, 3'd2, 3'd0}, 32'h44441000, 1, 3'd1, 4'b0010));
        vq.push_back(mk(0, 4'b0010, {3'd0, 3'd0, 3'd3, 3'd0}, 32'h44442000, 1, 3'd2, 4'b0010));
        vq.push_back(mk(0, 4'b0000, 12'h0, 32'h0, 1, 3'd3, 4'b0000));
        vq.push_back(mk(0, 4'b0000, 12'h0, 32'h0, 0, 3'd3, 4'b0000));
        vq.push_back(mk(0, 4'b0111, {3'd0, 3'd3, 3'd2, 3'd1}, 32'h55550000, 0, 3'd3, 4'b0111));
        vq.push_back(mk(1, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd5}, 32'h66660000, 0, 3'd3, 4'b0000));
        vq.push_back(mk(0, 4'b0000, 12'h0, 32'h0, 0, 3'd3, 4'b0000));
        vq.push_back(mk(0, 4'b0000, 12'h0, 32'h0, 0, 3'd3, 4'b0000));

        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_cdb_valid", 32'(cdb_valid), 32'd0);
        chk("rst_cdb_tag", 32'(cdb_tag), 32'd0);
        chk("rst_cdb_data", cdb_data, 32'd0);
        chk("rst_fu_busy", 32'(fu_busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'hF);
        @(negedge clk);

        for (int r = 0; r < vq.size(); r++) begin
            cycle(vq[r].fl, vq[r].v, vq[r].tg, vq[r].d);
            chk($sformatf("vec%0d_cdb_valid", r), 32'(cdb_valid), 32'(vq[r].cv));
            chk($sformatf("vec%0d_cdb_tag", r), 32'(cdb_tag), 32'(vq[r].tag));
            chk($sformatf("vec%0d_fu_busy", r), 32'(fu_busy), 32'(vq[r].busy));
        end
        chk("single_data", cdb_data, 32'h44442000 + 32'd0);

        // async reset between edges while a burst is in flight
        cycle(0, 4'b1111, {3'd4, 3'd3, 3'd2, 3'd1}, 32'h77770000);
        cycle(0, 4'b0000, 12'h0, 32'h0);
        chk("burst_cdb_valid", 32'(cdb_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_cdb_valid", 32'(cdb_valid), 32'd0);
        chk("async_fu_busy", 32'(fu_busy), 32'd0);
        chk("async_cdb_tag", 32'(cdb_tag), 32'd0);
        m_hv = '0; m_ptr = 0; sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        cycle(0, 4'b1001, {3'd6, 3'd0, 3'd0, 3'd7}, 32'h88880000);
        chk("post_rst_busy", 32'(fu_busy), 32'h9);
        cycle(0, 4'b0000, 12'h0, 32'h0);
        chk("post_rst_first_tag", 32'(cdb_tag), 32'd7);
        cycle(0, 4'b0000, 12'h0, 32'h0);
        chk("post_rst_second_tag", 32'(cdb_tag), 32'd6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
